// File: rtl/mdu_seq_if.sv
// mdu_seq_if: operation/result bundle between the E stage and the MDU sequencer.
//   start   - E-stage instruction is an MDU operation this cycle
//   md_type - operation code (0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//             5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9..15 none)
//   req     - exception/interrupt request flushing the E-stage instruction
//   rs, rt  - forwarded operands
//   busy    - operation in flight (to the stall controller)
//   md_out  - HI/LO read data for MFHI/MFLO
//   hi_q    - committed HI register
//   lo_q    - committed LO register
interface mdu_seq_if;
    logic        start;
    logic [3:0]  md_type;
    logic        req;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    modport master (
        output start, md_type, req, rs, rt,
        input  busy, md_out, hi_q, lo_q
    );

    modport slave (
        input  start, md_type, req, rs, rt,
        output busy, md_out, hi_q, lo_q
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multiply/divide sequencer for the E stage.
// Accepts one MDU operation per start pulse, computes the result on the
// accept edge into pending HI/LO registers, holds busy for a fixed per-class
// latency, then commits the pending result into hi_q/lo_q as busy falls.
// MTHI/MTLO write the committed registers directly; MFHI/MFLO read them
// combinationally through md_out. A start that coincides with req is dropped.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - mdu_seq_if.slave (start, md_type, req, rs, rt, busy, md_out, hi_q, lo_q)
module mdu_seq #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_seq_if.slave   bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        busy_r;
    logic [31:0] hi_q_r;
    logic [31:0] lo_q_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;
    logic        pend_ok_r;

    logic        accept_s;
    logic        div_ovf_s;
    logic        rt_zero_s;
    logic signed [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic signed [31:0] sden_s;
    logic signed [31:0] squo_s;
    logic signed [31:0] srem_s;
    logic [31:0] uden_s;
    logic [31:0] uquo_s;
    logic [31:0] urem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        res_ok_s;
    logic [7:0]  res_cnt_s;
    logic [31:0] md_out_s;

    assign accept_s  = bus.start && !bus.req && (state_r == ST_IDLE) &&
                       (bus.md_type >= OP_MULT) && (bus.md_type <= OP_MTLO);
    assign rt_zero_s = (bus.rt == 32'h0000_0000);
    assign div_ovf_s = (bus.rs == 32'h8000_0000) && (bus.rt == 32'hFFFF_FFFF);

    assign prod_s_s = $signed({{32{bus.rs[31]}}, bus.rs}) * $signed({{32{bus.rt[31]}}, bus.rt});
    assign prod_u_s = {32'h0000_0000, bus.rs} * {32'h0000_0000, bus.rt};

    // Divisors are forced to 1 for the zero-divisor and overflow cases so the
    // dividers never see an undefined operation; those cases are patched below.
    assign sden_s = (rt_zero_s || div_ovf_s) ? 32'sd1 : $signed(bus.rt);
    assign squo_s = $signed(bus.rs) / sden_s;
    assign srem_s = $signed(bus.rs) % sden_s;
    assign uden_s = rt_zero_s ? 32'd1 : bus.rt;
    assign uquo_s = bus.rs / uden_s;
    assign urem_s = bus.rs % uden_s;

    // Select the result, commit enable and latency for the requested operation.
    always_comb begin
        res_hi_s  = 32'h0000_0000;
        res_lo_s  = 32'h0000_0000;
        res_ok_s  = 1'b0;
        res_cnt_s = MULT_CNT;
        case (bus.md_type)
            OP_MULT: begin
                res_hi_s = prod_s_s[63:32];
                res_lo_s = prod_s_s[31:0];
                res_ok_s = 1'b1;
            end
            OP_MULTU: begin
                res_hi_s = prod_u_s[63:32];
                res_lo_s = prod_u_s[31:0];
                res_ok_s = 1'b1;
            end
            OP_DIV: begin
                res_cnt_s = DIV_CNT;
                res_ok_s  = !rt_zero_s;
                if (div_ovf_s) begin
                    res_hi_s = 32'h0000_0000;
                    res_lo_s = 32'h8000_0000;
                end else begin
                    res_hi_s = srem_s;
                    res_lo_s = squo_s;
                end
            end
            OP_DIVU: begin
                res_cnt_s = DIV_CNT;
                res_ok_s  = !rt_zero_s;
                res_hi_s  = urem_s;
                res_lo_s  = uquo_s;
            end
            default: begin
                res_ok_s = 1'b0;
            end
        endcase
    end

    // Sequencer: accept in IDLE, count down in RUN, commit on the last cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            busy_r    <= 1'b0;
            hi_q_r    <= 32'h0000_0000;
            lo_q_r    <= 32'h0000_0000;
            pend_hi_r <= 32'h0000_0000;
            pend_lo_r <= 32'h0000_0000;
            pend_ok_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (bus.md_type)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pend_hi_r <= res_hi_s;
                                pend_lo_r <= res_lo_s;
                                pend_ok_r <= res_ok_s;
                                cnt_r     <= res_cnt_s;
                                busy_r    <= 1'b1;
                                state_r   <= ST_RUN;
                            end
                            OP_MTHI: hi_q_r <= bus.rs;
                            OP_MTLO: lo_q_r <= bus.rs;
                            default: begin
                                // MFHI/MFLO only read through md_out
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt_r == 8'd1) begin
                        // A zero divisor leaves the committed registers untouched
                        if (pend_ok_r) begin
                            hi_q_r <= pend_hi_r;
                            lo_q_r <= pend_lo_r;
                        end
                        pend_ok_r <= 1'b0;
                        cnt_r     <= 8'd0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 8'd0;
                    busy_r    <= 1'b0;
                    pend_ok_r <= 1'b0;
                end
            endcase
        end
    end

    // HI/LO read port for MFHI/MFLO; other codes read as zero.
    always_comb begin
        md_out_s = 32'h0000_0000;
        case (bus.md_type)
            OP_MFHI: md_out_s = hi_q_r;
            OP_MFLO: md_out_s = lo_q_r;
            default: md_out_s = 32'h0000_0000;
        endcase
    end

    assign bus.busy   = busy_r;
    assign bus.hi_q   = hi_q_r;
    assign bus.lo_q   = lo_q_r;
    assign bus.md_out = md_out_s;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or shortly after it, away from the rising edge that updates state.
module tb_mdu_seq;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_busy;
    logic seen_bad;

    mdu_seq_if bus ();

    mdu_seq #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single rising edge, then scramble operands.
    task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic r);
        bus.start   = 1'b1;
        bus.md_type = t;
        bus.rs      = a;
        bus.rt      = b;
        bus.req     = r;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.md_type = 4'd0;
        bus.req     = 1'b0;
        bus.rs      = 32'hDEAD_BEEF;
        bus.rt      = 32'h0BAD_F00D;
    endtask

    // Count consecutive busy cycles, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.md_type = 4'd0;
        bus.req     = 1'b0;
        bus.rs      = 32'h0000_0000;
        bus.rt      = 32'h0000_0000;

        #1;
        check32("reset_busy", {31'd0, bus.busy}, 32'd0);
        check32("reset_hi", bus.hi_q, 32'h0000_0000);
        check32("reset_lo", bus.lo_q, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // MULT -1 * 2
        issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        check32("mult_no_early_commit", bus.lo_q, 32'h0000_0000);
        wait_idle(n_busy);
        check32("mult_busy_cycles", n_busy, 32'd5);
        check32("mult_hi", bus.hi_q, 32'hFFFF_FFFF);
        check32("mult_lo", bus.lo_q, 32'hFFFF_FFFE);

        // MULTU 0xFFFFFFFF * 2
        issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        wait_idle(n_busy);
        check32("multu_busy_cycles", n_busy, 32'd5);
        check32("multu_hi", bus.hi_q, 32'h0000_0001);
        check32("multu_lo", bus.lo_q, 32'hFFFF_FFFE);

        // DIV -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        wait_idle(n_busy);
        check32("div_busy_cycles", n_busy, 32'd10);
        check32("div_lo", bus.lo_q, 32'hFFFF_FFFD);
        check32("div_hi", bus.hi_q, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        issue(4'd4, 32'h0000_0007, 32'h0000_0002, 1'b0);
        wait_idle(n_busy);
        check32("divu_busy_cycles", n_busy, 32'd10);
        check32("divu_lo", bus.lo_q, 32'h0000_0003);
        check32("divu_hi", bus.hi_q, 32'h0000_0001);

        // DIV overflow case
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n_busy);
        check32("div_ovf_lo", bus.lo_q, 32'h8000_0000);
        check32("div_ovf_hi", bus.hi_q, 32'h0000_0000);

        // Preload via MTHI/MTLO, then divide by zero
        issue(4'd7, 32'h0000_00AA, 32'h0, 1'b0);
        check32("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issue(4'd8, 32'h0000_0055, 32'h0, 1'b0);
        check32("mthi_hi", bus.hi_q, 32'h0000_00AA);
        check32("mtlo_lo", bus.lo_q, 32'h0000_0055);
        issue(4'd3, 32'h0000_0005, 32'h0000_0000, 1'b0);
        wait_idle(n_busy);
        check32("div0_busy_cycles", n_busy, 32'd10);
        check32("div0_hi", bus.hi_q, 32'h0000_00AA);
        check32("div0_lo", bus.lo_q, 32'h0000_0055);

        // start together with req is suppressed
        issue(4'd1, 32'h0000_0007, 32'h0000_0009, 1'b1);
        check32("req_mult_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check32("req_mult_busy_later", {31'd0, bus.busy}, 32'd0);
        check32("req_mult_hi", bus.hi_q, 32'h0000_00AA);
        issue(4'd8, 32'h0000_1234, 32'h0, 1'b1);
        check32("req_mtlo_lo", bus.lo_q, 32'h0000_0055);

        // Second start on busy cycle 2 is ignored
        issue(4'd1, 32'h0000_0003, 32'h0000_0004, 1'b0);
        n_busy = 0;
        while (bus.busy === 1'b1 && n_busy < 300) begin
            n_busy++;
            if (n_busy == 2) begin
                bus.start   = 1'b1;
                bus.md_type = 4'd4;
                bus.rs      = 32'd100;
                bus.rt      = 32'd7;
            end else begin
                bus.start   = 1'b0;
                bus.md_type = 4'd0;
            end
            @(negedge clk);
        end
        bus.start   = 1'b0;
        bus.md_type = 4'd0;
        check32("ignore_busy_cycles", n_busy, 32'd5);
        check32("ignore_hi", bus.hi_q, 32'h0000_0000);
        check32("ignore_lo", bus.lo_q, 32'h0000_000C);
        @(negedge clk);
        check32("ignore_no_restart", {31'd0, bus.busy}, 32'd0);

        // Reset mid-run aborts the operation
        issue(4'd7, 32'h0000_0077, 32'h0, 1'b0);
        issue(4'd1, 32'h0000_0003, 32'h0000_0005, 1'b0);
        n_busy = 0;
        while (bus.busy === 1'b1 && n_busy < 300) begin
            n_busy++;
            if (n_busy == 3) begin
                break;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check32("abort_busy_cycle", n_busy, 32'd3);
        check32("abort_busy", {31'd0, bus.busy}, 32'd0);
        check32("abort_hi", bus.hi_q, 32'h0000_0000);
        check32("abort_lo", bus.lo_q, 32'h0000_0000);
        @(negedge clk);
        reset    = 1'b1;
        seen_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.hi_q !== 32'h0 || bus.lo_q !== 32'h0) begin
                seen_bad = 1'b1;
            end
        end
        check32("abort_no_commit", {31'd0, seen_bad}, 32'd0);

        // md_out reads
        issue(4'd7, 32'h0000_BEEF, 32'h0, 1'b0);
        issue(4'd8, 32'h0000_1234, 32'h0, 1'b0);
        bus.start   = 1'b1;
        bus.md_type = 4'd6;
        #1;
        check32("mflo_md_out", bus.md_out, 32'h0000_1234);
        bus.md_type = 4'd5;
        #1;
        check32("mfhi_md_out", bus.md_out, 32'h0000_BEEF);
        bus.md_type = 4'd12;
        bus.rs      = 32'h5555_AAAA;
        #1;
        check32("type12_md_out", bus.md_out, 32'h0000_0000);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.md_type = 4'd0;
        check32("type12_busy", {31'd0, bus.busy}, 32'd0);
        check32("type12_hi", bus.hi_q, 32'h0000_BEEF);
        check32("type12_lo", bus.lo_q, 32'h0000_1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
